// File: rtl/v810_bus_responder_if.sv
// V810 external data bus signal bundle.
// master: the CPU side that starts cycles; slave: the responding target.
interface v810_bus_responder_if;
    logic [31:0] DA;
    logic [31:0] DD_I;
    logic [31:0] DD_O;
    logic        DD_OE;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;

    modport master (
        output DA, DD_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        input  DD_O, DD_OE, READYn
    );

    modport slave (
        input  DA, DD_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        output DD_O, DD_OE, READYn
    );
endinterface

// File: rtl/v810_bus_responder.sv
// V810 external data bus responder: a word-array target that answers
// CPU bus cycles after a fixed number of wait states.
//
// Optional build macro: V810_BUS_RESPONDER_MISS_ACK_EN
//   When defined, requests outside the window (and instruction-fetch
//   status ST=2'b11) are acknowledged with the normal timing; reads return
//   all ones, writes are dropped. When undefined, misses are never answered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no cycle in flight; watching for BCYSTn with a decode hit
// WAIT  | cycle accepted, counting down wait states; inputs ignored
// DATA  | READYn low for one CE cycle; read data driven / write commits
module v810_bus_responder #(
    parameter int          AW    = 10,
    parameter logic [31:0] BASE  = 32'h0500_0000,
    parameter int          WAITS = 1
) (
    input logic                 CLK,
    input logic                 RES,
    input logic                 CE,
    v810_bus_responder_if.slave bus
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [3:0] WAIT_LOAD = 4'(WAITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            rw_q, rw_d;
    logic [3:0]      ben_q, ben_d;
    logic            miss_q, miss_d;
    logic            ready_n_q, ready_n_d;
    logic            dd_oe_q, dd_oe_d;
    logic [31:0]     dd_o_q, dd_o_d;

    logic [31:0]     mem_q [DEPTH];

    logic            win_hit;
    logic            req;
    logic            take;
    logic            take_miss;
    logic            wr_fire;
    logic [31:0]     wr_word;
    logic [31:0]     rd_word;
    logic            rd_data;
    logic            unused_sigs;

    // Replace the enabled bytes of a word with the new data.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  ben_n
    );
        logic [31:0] merged;
        merged = old_w;
        for (int n = 0; n < 4; n++) begin
            if (!ben_n[n]) begin
                merged[8*n +: 8] = new_w[8*n +: 8];
            end
        end
        return merged;
    endfunction

    // Byte lanes below word granularity never matter; ST only matters
    // with the miss-acknowledge build.
    assign unused_sigs = ^{bus.ST, bus.DA[1:0]};

    // Address decode and cycle-start qualification.
    always_comb begin
        win_hit = (bus.DA[31:AW+2] == BASE[31:AW+2]);
        req     = !bus.BCYSTn && !bus.MRQn && !bus.DAn;
`ifdef V810_BUS_RESPONDER_MISS_ACK_EN
        take      = req;
        take_miss = !win_hit || (bus.ST == 2'b11);
`else
        take      = req && win_hit;
        take_miss = 1'b0;
`endif
    end

    // Write commit of the cycle currently in DATA, with byte merging.
    always_comb begin
        wr_fire = (state_q == S_DATA) && !rw_q && !miss_q;
        wr_word = merge_bytes(mem_q[idx_q], bus.DD_I, ben_q);
    end

    // Next-state, cycle capture and wait-state countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        ben_d   = ben_q;
        miss_d  = miss_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                // DATA always falls back to IDLE unless a new cycle starts
                // in the same clock (back-to-back, no idle gap).
                state_d = S_IDLE;
                if (take) begin
                    idx_d  = bus.DA[AW+1:2];
                    rw_d   = bus.RW;
                    ben_d  = bus.BEn;
                    miss_d = take_miss;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs for the cycle about to be in DATA. A write that
    // commits on this same edge to the word being read is forwarded so a
    // back-to-back read sees the new data.
    always_comb begin
        rd_word = mem_q[idx_d];
        if (wr_fire && (idx_q == idx_d)) begin
            rd_word = wr_word;
        end
        rd_data   = (state_d == S_DATA) && rw_d;
        ready_n_d = (state_d != S_DATA);
        dd_oe_d   = rd_data;
        dd_o_d    = dd_o_q;
        if (rd_data) begin
            dd_o_d = miss_d ? 32'hFFFF_FFFF : rd_word;
        end
    end

    // Control and output registers; CE freezes everything, reset aborts.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                state_q   <= S_IDLE;
                cnt_q     <= 4'd0;
                idx_q     <= '0;
                rw_q      <= 1'b1;
                ben_q     <= 4'b1111;
                miss_q    <= 1'b0;
                ready_n_q <= 1'b1;
                dd_oe_q   <= 1'b0;
                dd_o_q    <= 32'd0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                idx_q     <= idx_d;
                rw_q      <= rw_d;
                ben_q     <= ben_d;
                miss_q    <= miss_d;
                ready_n_q <= ready_n_d;
                dd_oe_q   <= dd_oe_d;
                dd_o_q    <= dd_o_d;
            end
        end
    end

    // Word array; contents survive reset, and a reset edge drops the write.
    always_ff @(posedge CLK) begin
        if (CE && !RES && wr_fire) begin
            mem_q[idx_q] <= wr_word;
        end
    end

    assign bus.READYn = ready_n_q;
    assign bus.DD_OE  = dd_oe_q;
    assign bus.DD_O   = dd_o_q;

endmodule

// File: tb/tb_v810_bus_responder.sv
// Directed bench for v810_bus_responder. Three instances share one set of
// CPU-side inputs with WAITS = 0, 1 and 3; each check targets one instance.
module tb_v810_bus_responder;

    localparam logic [31:0] B = 32'h0500_0000;
`ifdef V810_BUS_RESPONDER_MISS_ACK_EN
    localparam bit MISS_ACK = 1'b1;
`else
    localparam bit MISS_ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        ce;
    logic [31:0] da;
    logic [31:0] dd_i;
    logic [3:0]  ben;
    logic [1:0]  st;
    logic        dan;
    logic        mrqn;
    logic        rw;
    logic        bcystn;

    logic [2:0]  rdy_a;
    logic [2:0]  oe_a;
    logic [31:0] do_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // index 0: WAITS=0, index 1: WAITS=1, index 2: WAITS=3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        v810_bus_responder_if bus_i ();
        assign bus_i.DA     = da;
        assign bus_i.DD_I   = dd_i;
        assign bus_i.BEn    = ben;
        assign bus_i.ST     = st;
        assign bus_i.DAn    = dan;
        assign bus_i.MRQn   = mrqn;
        assign bus_i.RW     = rw;
        assign bus_i.BCYSTn = bcystn;
        v810_bus_responder #(
            .AW   (10),
            .BASE (32'h0500_0000),
            .WAITS((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .CLK(clk),
            .RES(res),
            .CE (ce),
            .bus(bus_i)
        );
        assign rdy_a[g] = bus_i.READYn;
        assign oe_a[g]  = bus_i.DD_OE;
        assign do_a[g]  = bus_i.DD_O;
    end

    typedef struct {
        logic [31:0] da;
        logic [31:0] dd_i;
        logic [3:0]  ben;
        logic        rw;
        logic        mrqn;
        logic        dan;
        logic [1:0]  st;
        logic        ack;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic r,
                                input logic mq, input logic dn,
                                input logic [1:0] s, input logic ak,
                                input logic [31:0] ex);
        vec_t v;
        v.da = a; v.dd_i = d; v.ben = be; v.rw = r; v.mrqn = mq;
        v.dan = dn; v.st = s; v.ack = ak; v.exp = ex;
        return v;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bcystn = 1'b1;
        mrqn   = 1'b1;
        dan    = 1'b1;
        rw     = 1'b1;
        ben    = 4'b1111;
        st     = 2'b00;
    endtask

    // One bus cycle on instance s; checks latency, read data and release.
    task automatic run_vec(input int s, input vec_t v);
        int lat;
        lat    = 0;
        da     = v.da;
        dd_i   = v.dd_i;
        ben    = v.ben;
        rw     = v.rw;
        mrqn   = v.mrqn;
        dan    = v.dan;
        st     = v.st;
        bcystn = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) bcystn = 1'b1;
            if (rdy_a[s] == 1'b0) begin
                lat = n;
                break;
            end
        end
        if (v.ack) begin
            chk("latency", lat, lat_of(s));
            if (lat != 0) begin
                chk("oe_in_data", oe_a[s], v.rw);
                if (v.rw) chk("rdata", do_a[s], v.exp);
                tick();
                chk("ready_release", rdy_a[s], 1);
                chk("oe_release", oe_a[s], 0);
                if (v.rw) chk("rdata_hold", do_a[s], v.exp);
            end
        end else begin
            chk("no_ack", lat, 0);
        end
        idle_bus();
        repeat (6) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ce_cnt;
        logic prev_r;

        vecs[0]  = mk(B + 32'h8,   32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
        vecs[1]  = mk(B + 32'h8,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF);
        vecs[2]  = mk(B + 32'h8,   32'h1122_3344, 4'b1010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
        vecs[3]  = mk(B + 32'h8,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDE22_BE44);
        vecs[4]  = mk(B + 32'h0,   32'h1234_5678, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
        vecs[5]  = mk(B + 32'h0,   32'hAAAA_AAAA, 4'b1111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
        vecs[6]  = mk(B + 32'h0,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1234_5678);
        vecs[7]  = mk(B + 32'hFFF, 32'h0BAD_F00D, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
        vecs[8]  = mk(B + 32'hFFC, 32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0BAD_F00D);
        vecs[9]  = mk(B + 32'h1,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1234_5678);
        vecs[10] = mk(B + 32'h8,   32'h0,         4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
        vecs[11] = mk(B + 32'h8,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        vecs[12] = mk(B + 32'h1000, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, MISS_ACK, 32'hFFFF_FFFF);
        vecs[13] = mk(B - 32'h4,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, MISS_ACK, 32'hFFFF_FFFF);
        vecs[14] = mk(B + 32'h8,   32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1,
                      MISS_ACK ? 32'hFFFF_FFFF : 32'hDE22_BE44);

        res  = 1'b1;
        ce   = 1'b1;
        da   = 32'h0;
        dd_i = 32'h0;
        idle_bus();
        repeat (3) tick();
        res = 1'b0;
        tick();
        for (int s = 0; s < 3; s++) begin
            chk("rst_ready_n", rdy_a[s], 1);
            chk("rst_dd_oe", oe_a[s], 0);
            chk("rst_dd_o", do_a[s], 0);
        end

        for (int i = 0; i < 15; i++) begin
            run_vec(1, vecs[i]);
        end

        // Abort a write in WAIT: no READYn, no commit, outputs cleared.
        da     = B;
        dd_i   = 32'hCAFE_F00D;
        ben    = 4'b0000;
        rw     = 1'b0;
        mrqn   = 1'b0;
        dan    = 1'b0;
        bcystn = 1'b0;
        tick();
        bcystn = 1'b1;
        chk("abort_wait_ready", rdy_a[1], 1);
        res = 1'b1;
        tick();
        res = 1'b0;
        chk("abort_ready", rdy_a[1], 1);
        chk("abort_dd_oe", oe_a[1], 0);
        chk("abort_dd_o", do_a[1], 0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (rdy_a[1] == 1'b0 && lat == 0) lat = n;
        end
        chk("abort_no_ready", lat, 0);
        idle_bus();
        repeat (4) tick();
        run_vec(1, mk(B, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1234_5678));

        // Back-to-back write then read of the same word, WAITS=0.
        da     = B + 32'h4;
        dd_i   = 32'h5;
        ben    = 4'b0000;
        rw     = 1'b0;
        mrqn   = 1'b0;
        dan    = 1'b0;
        bcystn = 1'b0;
        tick();
        chk("b2b_wr_ready", rdy_a[0], 0);
        chk("b2b_wr_oe", oe_a[0], 0);
        rw = 1'b1;
        tick();
        chk("b2b_rd_ready", rdy_a[0], 0);
        chk("b2b_rd_oe", oe_a[0], 1);
        chk("b2b_rd_data", do_a[0], 32'h5);
        bcystn = 1'b1;
        tick();
        chk("b2b_release", rdy_a[0], 1);
        idle_bus();
        repeat (6) tick();

        // CE toggling during WAIT on the WAITS=3 instance.
        run_vec(2, mk(B + 32'h10, 32'h77, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0));
        da     = B + 32'h10;
        rw     = 1'b1;
        mrqn   = 1'b0;
        dan    = 1'b0;
        bcystn = 1'b0;
        ce     = 1'b1;
        tick();
        bcystn = 1'b1;
        ce_cnt = 1;
        lat    = 0;
        prev_r = rdy_a[2];
        for (int k = 0; k < 20; k++) begin
            ce = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (!ce) begin
                chk("ce_frozen_ready", rdy_a[2], prev_r);
            end else begin
                ce_cnt++;
                if (rdy_a[2] == 1'b0) begin
                    lat = ce_cnt;
                    break;
                end
            end
            prev_r = rdy_a[2];
        end
        chk("ce_latency", lat, 4);
        chk("ce_rd_oe", oe_a[2], 1);
        chk("ce_rd_data", do_a[2], 32'h77);
        ce = 1'b0;
        tick();
        chk("ce_frozen_data_ready", rdy_a[2], 0);
        chk("ce_frozen_data_oe", oe_a[2], 1);
        ce = 1'b1;
        tick();
        chk("ce_release_ready", rdy_a[2], 1);
        chk("ce_release_oe", oe_a[2], 0);
        idle_bus();
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
